apb_mem_slave: RTL and testbench

//  APB slave: a word-addressed register memory that sits downstream of the APB master and receives
//  one PSELx line from it. It decodes the address, inserts programmable wait states and supports

---
 rtl/apb_mem_slave.sv | 170 +++++++++++++++++
 tb/tb_apb_mem_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB word-addressed register memory with programmable wait
// states, byte-strobed writes and address-decode error reporting.
// All outputs are registered; PREADY is high for exactly one cycle per transfer.
module apb_mem_slave #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];

  logic              enter_done;
  logic              nxt_err;
  logic [IDX_W-1:0]  nxt_idx;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;

  // Error when misaligned, below the base address, or beyond the last word.
  // The borrow of the base subtraction flags addresses below BASE_ADDR.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a[1:0] != 2'b00) || diff[ADDR_W] || ((diff[ADDR_W-1:0] >> 2) >= ADDR_W'(DEPTH));
  endfunction

  // Word index relative to BASE_ADDR; only meaningful when addr_err is 0.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  // Decode both the address being committed (DONE) and the one that will be
  // latched at this edge, so a zero-wait read can load PRDATA straight from setup.
  always_comb begin
    cur_err = addr_err(addr_q);
    cur_idx = addr_idx(addr_q);
    nxt_err = addr_err(addr_d);
    nxt_idx = addr_idx(addr_d);
  end

  // Next-state, latch, response and memory-write logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prdata_d   = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    mem_d      = mem_q;
    enter_done = 1'b0;

    case (state_q)
      IDLE: begin
        // PSEL with PENABLE but no setup cycle is ignored here.
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (write_q && !cur_err) begin
          for (int unsigned n = 0; n < 4; n++) begin
            if (strb_q[n]) begin
              mem_d[cur_idx][8*n +: 8] = wdata_q[8*n +: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Response is loaded on the edge entering DONE so it is registered.
    if (enter_done) begin
      pready_d  = 1'b1;
      pslverr_d = nxt_err;
      if (!write_d && !nxt_err) begin
        prdata_d = mem_q[nxt_idx];
      end
    end
  end

  // State, outputs and memory; reset clears everything and drops any transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      mem_q     <= mem_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: three apb_mem_slave instances (1, 0 and 3 wait states, the
// last with a non-zero base and 16 words) driven by directed and random APB
// transfers; expectations come from a word-array model and are checked by a
// monitor that pops a per-instance queue whenever PREADY is seen.
module tb_apb_mem_slave;

  localparam int NDUT = 3;
  localparam int unsigned WAITS  [NDUT] = '{1, 0, 3};
  localparam int unsigned DEPTHS [NDUT] = '{64, 64, 16};
  localparam logic [31:0] BASES  [NDUT] = '{32'h0, 32'h0, 32'h100};

  logic              clk;
  logic              preset;
  logic [NDUT-1:0]   psel, penable, pwrite;
  logic [31:0]       paddr  [NDUT];
  logic [31:0]       pwdata [NDUT];
  logic [3:0]        pstrb  [NDUT];
  logic [31:0]       prdata [NDUT];
  logic [NDUT-1:0]   pready, pslverr;

  // expectation word: {check_data, err, data}
  logic [33:0]       expq [NDUT][$];
  logic [31:0]       mdl  [NDUT][64];

  int total;
  int bad;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_mem_slave #(
      .ADDR_W      (32),
      .DEPTH       (DEPTHS[g]),
      .WAIT_CYCLES (WAITS[g]),
      .BASE_ADDR   (BASES[g])
    ) u_dut (
      .PCLK    (clk),
      .PRESET  (preset),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PSTRB   (pstrb[g]),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic bit model_err(input int d, input logic [31:0] a);
    longint aa;
    longint b;
    aa = longint'(a);
    b  = longint'(BASES[d]);
    if (aa % 4 != 0) return 1'b1;
    if (aa < b) return 1'b1;
    if ((aa - b) / 4 >= longint'(DEPTHS[d])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_idx(input int d, input logic [31:0] a);
    return int'((longint'(a) - longint'(BASES[d])) / 4);
  endfunction

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < 64; w++)
        mdl[d][w] = '0;
  endtask

  task automatic idle(input int n);
    psel    = '0;
    penable = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One complete APB transfer; address/data/strobe are scrambled after setup.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    bit          err;
    logic [31:0] rd;
    int          n;
    bit          got;
    err = model_err(d, a);
    rd  = '0;
    if (!err) begin
      if (wr) begin
        for (int l = 0; l < 4; l++)
          if (st[l]) mdl[d][model_idx(d, a)][8*l +: 8] = wd[8*l +: 8];
      end else begin
        rd = mdl[d][model_idx(d, a)];
      end
    end
    expq[d].push_back({!wr && !err, err, rd});

    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    pstrb[d]   = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    paddr[d]   = $urandom;
    pwdata[d]  = $urandom;
    pstrb[d]   = 4'($urandom);
    n   = 1;
    got = 1'b0;
    while (!got && n <= 16) begin
      @(negedge clk);
      if (pready[d]) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got) begin
      chk("ready_timeout", d, 32'(n), 32'(WAITS[d] + 1));
      if (expq[d].size() > 0) void'(expq[d].pop_back());
    end else begin
      chk("ready_latency", d, 32'(n), 32'(WAITS[d] + 1));
    end
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Write whose PSEL is dropped in the first access cycle.
  task automatic abort_wr(input int d, input logic [31:0] a, input logic [31:0] wd);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b1;
    paddr[d]   = a;
    pwdata[d]  = wd;
    pstrb[d]   = 4'hF;
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    repeat (WAITS[d] + 2) @(posedge clk);
    #1;
  endtask

  // Reset asserted for two cycles during the wait state of a write.
  task automatic reset_mid_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b1;
    paddr[d]   = a;
    pwdata[d]  = wd;
    pstrb[d]   = 4'hF;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    preset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_pready", k, 32'(pready[k]), 32'd0);
      chk("rst_pslverr", k, 32'(pslverr[k]), 32'd0);
      chk("rst_prdata", k, prdata[k], 32'd0);
    end
    @(posedge clk); #1;
    preset  = 1'b0;
    psel    = '0;
    penable = '0;
    clear_model();
  endtask

  // Scoreboard monitor: pops an expectation for every PREADY, else outputs must be 0.
  always @(negedge clk) begin
    if (!preset) begin
      for (int d = 0; d < NDUT; d++) begin
        if (pready[d]) begin
          if (expq[d].size() == 0) begin
            chk("unexpected_ready", d, 32'd1, 32'd0);
          end else begin
            logic [33:0] e;
            e = expq[d].pop_front();
            chk("pslverr", d, 32'(pslverr[d]), 32'(e[32]));
            if (e[33]) chk("prdata", d, prdata[d], e[31:0]);
          end
        end else begin
          chk("idle_prdata", d, prdata[d], 32'd0);
          chk("idle_pslverr", d, 32'(pslverr[d]), 32'd0);
        end
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    preset  = 1'b1;
    psel    = '0;
    penable = '0;
    pwrite  = '0;
    for (int d = 0; d < NDUT; d++) begin
      paddr[d]  = '0;
      pwdata[d] = '0;
      pstrb[d]  = '0;
    end
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_pready", d, 32'(pready[d]), 32'd0);
      chk("reset_pslverr", d, 32'(pslverr[d]), 32'd0);
      chk("reset_prdata", d, prdata[d], 32'd0);
    end
    @(posedge clk); #1;
    preset = 1'b0;
    idle(1);

    // T1: reset during a write's wait state; word must read back as zero
    xfer(0, 1'b1, 32'h4, 32'h1234_5678, 4'hF);
    reset_mid_write(0, 32'h4, 32'hAAAA_5555);
    idle(1);
    xfer(0, 1'b0, 32'h4, '0, 4'h0);

    // T2/T3: full write, read, strobed write, read
    xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 1'b0, 32'h4, '0, 4'h0);
    xfer(0, 1'b1, 32'h4, 32'h1122_3344, 4'b0101);
    xfer(0, 1'b0, 32'h4, '0, 4'hF);

    // T4: out-of-range and misaligned writes, then clean reads
    xfer(0, 1'b1, 32'h100, 32'h5555_5555, 4'hF);
    xfer(0, 1'b1, 32'h6, 32'h6666_6666, 4'hF);
    xfer(0, 1'b0, 32'h4, '0, 4'h0);
    xfer(0, 1'b0, 32'h4, '0, 4'h0);
    xfer(0, 1'b0, 32'hFC, '0, 4'h0);
    xfer(0, 1'b1, 32'h0, 32'h0, 4'h0);

    // T5: aborted write leaves the prior value
    xfer(0, 1'b1, 32'h8, 32'h0BAD_0001, 4'hF);
    abort_wr(0, 32'h8, 32'hCAFE_F00D);
    xfer(0, 1'b0, 32'h8, '0, 4'h0);

    // Access phase without setup must be ignored
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'hFFFF_FFFF; pstrb[0] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    idle(1);
    xfer(0, 1'b0, 32'h4, '0, 4'h0);

    // T6: back-to-back on the zero-wait instance
    xfer(1, 1'b1, 32'h8, 32'hA5A5_0008, 4'hF);
    xfer(1, 1'b1, 32'hC, 32'h5A5A_000C, 4'hF);
    xfer(1, 1'b0, 32'h8, '0, 4'h0);
    xfer(1, 1'b0, 32'hC, '0, 4'h0);

    // Base-offset instance boundaries
    xfer(2, 1'b1, 32'h0FC, 32'h1, 4'hF);
    xfer(2, 1'b1, 32'h100, 32'h1111_0100, 4'hF);
    xfer(2, 1'b1, 32'h13C, 32'h2222_013C, 4'hF);
    xfer(2, 1'b1, 32'h140, 32'h3, 4'hF);
    xfer(2, 1'b0, 32'h100, '0, 4'h0);
    xfer(2, 1'b0, 32'h13C, '0, 4'h0);
    idle(2);

    // Random mix
    for (int it = 0; it < 300; it++) begin
      int          d;
      int          w;
      logic [31:0] a;
      d = int'($urandom_range(0, NDUT - 1));
      w = int'($urandom_range(0, DEPTHS[d] + 3));
      a = BASES[d] + 32'(w * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if (BASES[d] != 0 && $urandom_range(0, 9) == 0) a = BASES[d] - 32'($urandom_range(1, 16));
      if (WAITS[d] > 0 && $urandom_range(0, 9) == 0)
        abort_wr(d, a, $urandom);
      else
        xfer(d, 1'($urandom), a, $urandom, 4'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(6);
    for (int d = 0; d < NDUT; d++)
      chk("queue_drained", d, 32'(expq[d].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
